// File: rtl/matrix_feeder.sv
// Feeds one ROWS x LENGTH matrix to per-row shift registers with diagonal skew; load takes 1 cycle, feed LENGTH+ROWS-1.
// Latency start->done is LENGTH+ROWS cycles; no backpressure, start is ignored (not queued) while not idle.
module matrix_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  parameter int ROWS       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] matrix_in [ROWS*LENGTH],
  output logic [DATA_WIDTH-1:0] load_data [ROWS*LENGTH],
  output logic [1:0]            ctrl_code [ROWS],
  output logic [ROWS-1:0]       row_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FEED = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] CODE_HOLD  = 2'b00;
  localparam logic [1:0] CODE_LOAD  = 2'b01;
  localparam logic [1:0] CODE_SHIFT = 2'b11;

  localparam int N_ELEM = ROWS * LENGTH;
  localparam int LAST   = LENGTH + ROWS - 2;
  localparam int CNT_W  = (LENGTH + ROWS > 2) ? $clog2(LENGTH + ROWS) : 1;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture;
  logic [1:0]       ctrl_nxt [ROWS];
  logic [ROWS-1:0]  row_valid_nxt;

  // Next-state logic; clear overrides everything, including a start in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_LOAD;
            capture   = 1'b1;
          end
        end
        S_LOAD: begin
          state_nxt = S_FEED;
          cnt_nxt   = '0;
        end
        S_FEED: begin
          if (cnt == CNT_W'(LAST)) begin
            state_nxt = S_DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered with no extra cycle of lag.
  always_comb begin
    row_valid_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      ctrl_nxt[r] = CODE_HOLD;
      if (state_nxt == S_LOAD) begin
        ctrl_nxt[r] = CODE_LOAD;
      end else if (state_nxt == S_FEED &&
                   cnt_nxt >= CNT_W'(r) && cnt_nxt < CNT_W'(r + LENGTH)) begin
        ctrl_nxt[r]      = CODE_SHIFT;
        row_valid_nxt[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      row_valid <= '0;
      for (int r = 0; r < ROWS; r++) begin
        ctrl_code[r] <= CODE_HOLD;
      end
      for (int i = 0; i < N_ELEM; i++) begin
        load_data[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt == S_LOAD) || (state_nxt == S_FEED);
      done      <= (state_nxt == S_DONE);
      row_valid <= row_valid_nxt;
      for (int r = 0; r < ROWS; r++) begin
        ctrl_code[r] <= ctrl_nxt[r];
      end
      if (capture) begin
        for (int i = 0; i < N_ELEM; i++) begin
          load_data[i] <= matrix_in[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder: per-cycle vector table plus async-reset and single-row sequences.
module tb_matrix_feeder;

  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int RW  = 4;
  localparam int N   = RW * LEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          start, clear;
  logic [DW-1:0] matrix_in [N];
  logic [DW-1:0] load_data [N];
  logic [1:0]    ctrl_code [RW];
  logic [RW-1:0] row_valid;
  logic          busy, done;

  logic          start1, clear1;
  logic [DW-1:0] m1_in [LEN];
  logic [DW-1:0] ld1 [LEN];
  logic [1:0]    cc1 [1];
  logic [0:0]    rv1;
  logic          busy1, done1;

  matrix_feeder #(.DATA_WIDTH(DW), .LENGTH(LEN), .ROWS(RW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .matrix_in(matrix_in), .load_data(load_data), .ctrl_code(ctrl_code),
    .row_valid(row_valid), .busy(busy), .done(done)
  );

  matrix_feeder #(.DATA_WIDTH(DW), .LENGTH(LEN), .ROWS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .clear(clear1),
    .matrix_in(m1_in), .load_data(ld1), .ctrl_code(cc1),
    .row_valid(rv1), .busy(busy1), .done(done1)
  );

  // Downstream shift register for the single-row instance; head element is data_read.
  logic [DW-1:0] sr [LEN];
  logic [DW-1:0] data_read;
  assign data_read = sr[0];
  always @(posedge clk) begin
    if (cc1[0] == 2'b01) begin
      for (int i = 0; i < LEN; i++) sr[i] <= ld1[i];
    end else if (cc1[0] == 2'b11) begin
      for (int i = 0; i < LEN - 1; i++) sr[i] <= sr[i+1];
      sr[LEN-1] <= '0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pack_ctrl();
    logic [7:0] v;
    for (int r = 0; r < RW; r++) v[r*2 +: 2] = ctrl_code[r];
    return v;
  endfunction

  function automatic logic [127:0] pack_load();
    logic [127:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = load_data[i];
    return v;
  endfunction

  function automatic logic [127:0] exp_load(input int base);
    logic [127:0] v;
    for (int i = 0; i < N; i++) v[i*8 +: 8] = (base < 0) ? 8'h00 : 8'(base + i);
    return v;
  endfunction

  task automatic set_matrix(input int base);
    for (int i = 0; i < N; i++) matrix_in[i] = 8'(base + i);
  endtask

  typedef struct {
    logic       start;
    logic       clear;
    int         in_base;
    logic [7:0] ctrl;
    logic [3:0] rv;
    logic       busy;
    logic       done;
    int         ld_base;
  } vec_t;

  vec_t vecs[$];

  // Expected FEED patterns for cnt=0..6, hand-derived from the r <= cnt < r+4 window.
  logic [7:0] feed_ctrl [7] = '{8'h03, 8'h0F, 8'h3F, 8'hFF, 8'hFC, 8'hF0, 8'hC0};
  logic [3:0] feed_rv   [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  task automatic add(input logic s, input logic c, input int ib, input logic [7:0] ct,
                     input logic [3:0] rv, input logic b, input logic d, input int lb);
    vec_t v;
    v.start = s; v.clear = c; v.in_base = ib; v.ctrl = ct;
    v.rv = rv; v.busy = b; v.done = d; v.ld_base = lb;
    vecs.push_back(v);
  endtask

  // Full 10-vector run; poke_a/poke_b re-assert start with another matrix at those run indices.
  task automatic add_run(input int base, input int poke_a, input int poke_b, input int poke_base);
    add(1'b1, 1'b0, base, 8'h55, 4'h0, 1'b1, 1'b0, base);
    for (int j = 1; j <= 9; j++) begin
      logic p;
      p = (j == poke_a) || (j == poke_b);
      if (j <= 7)
        add(p, 1'b0, p ? poke_base : base, feed_ctrl[j-1], feed_rv[j-1], 1'b1, 1'b0, base);
      else if (j == 8)
        add(p, 1'b0, p ? poke_base : base, 8'h00, 4'h0, 1'b0, 1'b1, base);
      else
        add(p, 1'b0, p ? poke_base : base, 8'h00, 4'h0, 1'b0, 1'b0, base);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_rv0;
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; set_matrix(0);
    start1 = 1'b0; clear1 = 1'b0;
    for (int i = 0; i < LEN; i++) m1_in[i] = '0;

    #12;
    check("reset ctrl", pack_ctrl(), 8'h00);
    check("reset busy/done/rv", {busy, done, row_valid}, 6'h0);
    check("reset load", pack_load(), exp_load(-1));
    check("reset dut1", {busy1, done1, cc1[0]}, 4'h0);
    @(negedge clk); reset_n = 1'b1;

    add_run(1, -1, -1, 0);
    add_run(40, 4, 9, 200);
    add(1'b1, 1'b1, 90, 8'h00, 4'h0, 1'b0, 1'b0, 40);
    add(1'b0, 1'b0, 90, 8'h00, 4'h0, 1'b0, 1'b0, 40);
    add(1'b1, 1'b0, 20, 8'h55, 4'h0, 1'b1, 1'b0, 20);
    add(1'b0, 1'b0, 20, 8'h03, 4'h1, 1'b1, 1'b0, 20);
    add(1'b0, 1'b0, 20, 8'h0F, 4'h3, 1'b1, 1'b0, 20);
    add(1'b0, 1'b0, 20, 8'h3F, 4'h7, 1'b1, 1'b0, 20);
    add(1'b0, 1'b1, 20, 8'h00, 4'h0, 1'b0, 1'b0, 20);
    add(1'b0, 1'b0, 20, 8'h00, 4'h0, 1'b0, 1'b0, 20);
    add(1'b0, 1'b0, 20, 8'h00, 4'h0, 1'b0, 1'b0, 20);
    add_run(30, -1, -1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      start = vecs[i].start;
      clear = vecs[i].clear;
      set_matrix(vecs[i].in_base);
      @(posedge clk); #1;
      check($sformatf("v%0d ctrl", i), pack_ctrl(), vecs[i].ctrl);
      check($sformatf("v%0d row_valid", i), row_valid, vecs[i].rv);
      check($sformatf("v%0d busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d done", i), done, vecs[i].done);
      check($sformatf("v%0d load", i), pack_load(), exp_load(vecs[i].ld_base));
    end

    // Asynchronous reset between edges during FEED.
    @(negedge clk); start = 1'b1; clear = 1'b0; set_matrix(60);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre-reset feeding", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async ctrl", pack_ctrl(), 8'h00);
    check("async busy/done/rv", {busy, done, row_valid}, 6'h0);
    check("async load", pack_load(), exp_load(-1));
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset idle%0d", k), {pack_ctrl(), busy, done}, 10'h0);
    end

    @(negedge clk); start = 1'b1; set_matrix(70);
    @(posedge clk); #1;
    check("restart ctrl", pack_ctrl(), 8'h55);
    check("restart load", pack_load(), exp_load(70));
    @(negedge clk); start = 1'b0;
    cnt_rv0 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (row_valid[0]) cnt_rv0++;
      if (k == 8) check("restart done", done, 1'b1);
    end
    check("restart row0 shifts", cnt_rv0, 4);

    // Single-row instance feeding a shift register.
    @(negedge clk); start1 = 1'b1;
    for (int i = 0; i < LEN; i++) m1_in[i] = 8'(i + 1);
    @(posedge clk); #1;
    check("r1 load code", cc1[0], 2'b01);
    check("r1 load busy", busy1, 1'b1);
    @(negedge clk); start1 = 1'b0;
    for (int i = 0; i < LEN; i++) m1_in[i] = 8'hEE;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k <= 4) begin
        check($sformatf("r1 code%0d", k), {cc1[0], rv1}, {2'b11, 1'b1});
        check($sformatf("r1 data%0d", k), data_read, 8'(k));
      end else begin
        check("r1 done", {done1, busy1, cc1[0]}, 4'b1000);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one matrix element.
REQ-002 Parameter LENGTH, default 4, elements per row, equal to LENGTH of each downstream shift_reg.
REQ-003 Parameter ROWS, default 4, number of rows, one downstream shift_reg per row.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to feed one matrix; sampled only in IDLE.
REQ-007 clear  input  1  synchronous abort; returns block to IDLE.
REQ-008 matrix_in  input  DATA_WIDTH x ROWS*LENGTH (unpacked, element r*LENGTH+c = row r, column c)  matrix to feed.
REQ-009 load_data  output  DATA_WIDTH x ROWS*LENGTH (unpacked, same indexing)  registered copy of matrix_in; row r slice drives data_in of shift_reg r.
REQ-010 ctrl_code  output  2 x ROWS (unpacked, index r)  control code for shift_reg r: 00 hold, 01 parallel load, 11 shift out; 10 never driven.
REQ-011 row_valid  output  ROWS  bit r high in every cycle where ctrl_code[r]=11.
REQ-012 busy  output  1  high in LOAD and FEED.
REQ-013 done  output  1  one-cycle pulse at end of feed.

Function
REQ-014 All outputs are registered; no combinational path from any input to any output.
REQ-015 FSM states: IDLE, LOAD, FEED, DONE.
REQ-016 IDLE: all ctrl_code=00, row_valid=0, busy=0, done=0; start=1 at an edge -> LOAD, and matrix_in is captured into load_data at that same edge.
REQ-017 load_data changes only at the edge that leaves IDLE on start; it is held at all other times, including through DONE and back in IDLE.
REQ-018 LOAD: lasts exactly 1 cycle; all ctrl_code=01, busy=1; then -> FEED with cycle counter cnt=0.
REQ-019 FEED: lasts exactly LENGTH+ROWS-1 cycles, cnt=0..LENGTH+ROWS-2; ctrl_code[r]=11 when r <= cnt < r+LENGTH, else 00 (diagonal skew: row r starts r cycles after row 0).
REQ-020 In FEED each row sees exactly LENGTH consecutive cycles of 11; row 0 occupies cnt 0..LENGTH-1, row ROWS-1 occupies cnt ROWS-1..LENGTH+ROWS-2.
REQ-021 After cnt=LENGTH+ROWS-2 -> DONE; DONE lasts 1 cycle with done=1, busy=0, all ctrl_code=00; then -> IDLE.
REQ-022 Latency: start sampled at edge k -> ctrl_code=01 after edge k, first 11 on row 0 after edge k+1, done=1 after edge k+LENGTH+ROWS.
REQ-023 start while busy or in DONE is ignored, not queued.
REQ-024 clear=1 at an edge in any state -> IDLE at that edge, all ctrl_code=00, row_valid=0, busy=0, done=0; load_data is held.
REQ-025 clear and start both high in IDLE: clear wins; no capture, remain IDLE.
REQ-026 cnt is wide enough for LENGTH+ROWS-1 without wrap; cnt is reset to 0 on entry to FEED.
REQ-027 ROWS=1 is legal: FEED lasts LENGTH cycles.

Reset
REQ-028 reset_n=0 asynchronously forces IDLE, cnt=0, all ctrl_code=00, row_valid=0, busy=0, done=0, all load_data=0, regardless of clk.
REQ-029 Reset asserted mid-LOAD or mid-FEED aborts immediately with no further 01/11 codes; after release, the block waits in IDLE for a new start.

Verification
REQ-030 Defaults, matrix_in[i]=i+1, one-cycle start -> one cycle all ctrl_code=01 with load_data[i]=i+1; then FEED 7 cycles; ctrl_code[0]=11 in cycles 0-3, [1] in 1-4, [2] in 2-5, [3] in 3-6; done pulse in cycle 8 after start.
REQ-031 Pulse start again during FEED with a different matrix_in -> ignored: load_data unchanged, exactly one done pulse.
REQ-032 clear at FEED cnt=2 -> next cycle all ctrl_code=00, busy=0, no done pulse; new start then runs a full, correct sequence.
REQ-033 reset_n low mid-FEED between clock edges -> outputs 0/00 immediately, without waiting for an edge; after release, idle until start.
REQ-034 start and clear high together in IDLE -> remains IDLE, load_data unchanged.
REQ-035 ROWS=1, LENGTH=4, connected to one shift_reg preloaded with 1,2,3,4 -> 01 for 1 cycle, 11 for 4 cycles; data_read presents 1,2,3,4 in order, then done.
